dbus_sram_responder: RTL

Responder (slave) end of the core's DBus request/response protocol, the counterpart of the AGU and store-buffer initiator. It accepts requests with an addr_ok handshake and queues them in an in-order outstanding FIFO. Each request is serviced against a local word-wide synchronous SRAM with a programmable wait latency, and completion is returned as a one-cycle data_ok pulse. It serves as the data-memory model for core-level simulation and as the on-chip scratchpad behind the DBus.

---
 rtl/dbus_sram_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : dbus_sram_responder
// Brief    : DBus responder that queues accepted requests in an in-order FIFO
//            and services them against a word-wide synchronous SRAM with a
//            programmable wait latency. Each request gets one data_ok pulse.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_sram_responder #(
    parameter int RAM_AW  = 10,
    parameter int DEPTH   = 2,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dcache_req,
    input  logic              dcache_wr,
    input  logic [3:0]        dcache_wstrb,
    input  logic [2:0]        dcache_size,
    input  logic [31:0]       dcache_addr,
    input  logic [31:0]       dcache_wdata,
    output logic              dcache_addr_ok,
    output logic              dcache_data_ok,
    output logic [31:0]       dcache_rdata,
    output logic [3:0]        outstanding,
    input  logic [RAM_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_rdata
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]         c_DEPTH    = 4'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(DEPTH - 1);
    localparam logic [2:0]         c_LAT_M1   = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
    localparam bit                 c_ZERO_LAT = (LATENCY == 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    // Request queue storage (data only, no reset needed)
    logic              r_fifo_wr    [0:DEPTH-1];
    logic [3:0]        r_fifo_wstrb [0:DEPTH-1];
    logic [2:0]        r_fifo_size  [0:DEPTH-1];
    logic [RAM_AW-1:0] r_fifo_idx   [0:DEPTH-1];
    logic [31:0]       r_fifo_wdata [0:DEPTH-1];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [3:0]         r_count;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;

    logic [31:0] r_mem [0:(1<<RAM_AW)-1];

    logic              w_push;
    logic              w_pop;
    logic              w_access;
    logic              w_head_wr;
    logic [3:0]        w_head_wstrb;
    logic [2:0]        w_head_size;
    logic [RAM_AW-1:0] w_head_idx;
    logic [31:0]       w_head_wdata;
    logic [RAM_AW-1:0] w_req_idx;

    // No pop-through: a full queue refuses even when the head pops this cycle
    assign dcache_addr_ok = dcache_req && !reset && (r_count < c_DEPTH);
    assign w_push         = dcache_req && dcache_addr_ok;
    assign w_pop          = (r_state == c_ST_RESP);
    assign w_req_idx      = dcache_addr[RAM_AW+1:2];

    assign w_head_wr    = r_fifo_wr[r_rptr];
    assign w_head_wstrb = r_fifo_wstrb[r_rptr];
    assign w_head_size  = r_fifo_size[r_rptr];
    assign w_head_idx   = r_fifo_idx[r_rptr];
    assign w_head_wdata = r_fifo_wdata[r_rptr];

    // The SRAM is touched once per request: straight from IDLE with zero
    // latency, otherwise on the last WAIT cycle.
    assign w_access = ((r_state == c_ST_IDLE) && (r_count != 4'd0) && c_ZERO_LAT) ||
                      ((r_state == c_ST_WAIT) && (r_cnt == 3'd0));

    assign dcache_data_ok = (r_state == c_ST_RESP);
    assign dcache_rdata   = r_rdata;
    assign outstanding    = r_count;
    assign dbg_rdata      = r_mem[dbg_addr];

    // Size is carried with the request for tracing but does not steer the
    // datapath; byte-offset and aliased upper address bits are ignored.
    logic w_unused;
    assign w_unused = &{1'b0, w_head_size, dcache_addr[31:RAM_AW+2], dcache_addr[1:0]};

    // Capture accepted request fields at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[r_wptr]    <= dcache_wr;
            r_fifo_wstrb[r_wptr] <= dcache_wstrb;
            r_fifo_size[r_wptr]  <= dcache_size;
            r_fifo_idx[r_wptr]   <= w_req_idx;
            r_fifo_wdata[r_wptr] <= dcache_wdata;
        end
    end

    // Queue pointers and occupancy; pointers wrap modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= 4'd0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Service FSM for the queue head: IDLE -> (WAIT) -> RESP -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != 4'd0) begin
                        if (c_ZERO_LAT) begin
                            r_state <= c_ST_RESP;
                        end else begin
                            r_cnt   <= c_LAT_M1;
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Read-data register: loaded on access, held otherwise; writes return 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 32'd0;
        end else if (w_access) begin
            r_rdata <= w_head_wr ? 32'd0 : r_mem[w_head_idx];
        end
    end

    // Byte-lane SRAM write; an access cycle overlapped by reset is dropped
    always_ff @(posedge clk) begin
        if (w_access && w_head_wr && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (w_head_wstrb[i]) begin
                    r_mem[w_head_idx][8*i +: 8] <= w_head_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
